// File: rtl/fft_modulus_fifo_reader.sv
// Drains the FFT modulus prefetch FIFO frame by frame. It converts each squared modulus into a
// saturated magnitude stream and reports the peak bin and any length error for each frame.
module fft_modulus_fifo_reader #(
    parameter int FRAME_LEN = 8192,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_vld,
    input  logic [72:0]      fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_mag,
    output logic [12:0]      m_bin,
    output logic             m_last,
    output logic             peak_vld,
    output logic [12:0]      peak_bin,
    output logic [58:0]      peak_mag,
    output logic             len_err,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

    localparam logic [13:0] LEN_W14  = 14'(FRAME_LEN);
    localparam logic [12:0] LAST_BIN = 13'(FRAME_LEN - 1);

    state_t      state, state_nxt;
    logic        first_p0;
    logic [58:0] max_mag_p0;
    logic [12:0] max_bin_p0;
    logic [13:0] cnt_p0;
    logic        err_p0;

    logic        word_last;
    logic [12:0] word_bin;
    logic [58:0] word_mod;
    logic        in_frame;
    logic        pop_frame;
    logic        take_max;
    logic [58:0] max_mag_nxt;
    logic [12:0] max_bin_nxt;
    logic        bin_bad;
    logic        frame_bad;

    function automatic logic [OUT_W-1:0] sat_mag(input logic [58:0] mod);
        logic [58:0] s;
        s = mod >> SHIFT;
        if ((s >> OUT_W) != 59'd0)
            sat_mag = {OUT_W{1'b1}};
        else
            sat_mag = s[OUT_W-1:0];
    endfunction

    assign word_last = fifo_rd_data[72];
    assign word_bin  = fifo_rd_data[71:59];
    assign word_mod  = fifo_rd_data[58:0];

    assign in_frame   = (state == RUN) || (state == DRAIN);
    assign fifo_rd_en = fifo_rd_vld && ((state == SYNC) || (in_frame && (!m_valid || m_ready)));
    assign pop_frame  = fifo_rd_en && in_frame;
    assign busy       = (state != IDLE);

    // The first word of a frame always wins; after that only a strictly larger value wins, so the lowest bin keeps ties.
    assign take_max    = first_p0 || (word_mod > max_mag_p0);
    assign max_mag_nxt = take_max ? word_mod : max_mag_p0;
    assign max_bin_nxt = take_max ? word_bin : max_bin_p0;
    assign bin_bad     = {1'b0, word_bin} != cnt_p0;
    assign frame_bad   = err_p0 || bin_bad || ((cnt_p0 + 14'd1) != LEN_W14) || (word_bin != LAST_BIN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (enable) state_nxt = SYNC;
            SYNC: begin
                if (!enable)                      state_nxt = IDLE;
                else if (fifo_rd_en && word_last) state_nxt = RUN;
            end
            RUN: begin
                if (pop_frame && word_last) state_nxt = enable ? RUN : IDLE;
                else if (!enable)           state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop_frame && word_last) state_nxt = IDLE;
                else if (enable)            state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: output register, running frame statistics and per-frame summary
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m_valid    <= 1'b0;
            m_mag      <= '0;
            m_bin      <= '0;
            m_last     <= 1'b0;
            peak_vld   <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            len_err    <= 1'b0;
            frame_cnt  <= '0;
            first_p0   <= 1'b1;
            max_mag_p0 <= '0;
            max_bin_p0 <= '0;
            cnt_p0     <= '0;
            err_p0     <= 1'b0;
        end else begin
            state    <= state_nxt;
            peak_vld <= 1'b0;
            len_err  <= 1'b0;
            if (pop_frame) begin
                m_valid <= 1'b1;
                m_mag   <= sat_mag(word_mod);
                m_bin   <= word_bin;
                m_last  <= word_last;
                if (word_last) begin
                    peak_vld  <= 1'b1;
                    peak_bin  <= max_bin_nxt;
                    peak_mag  <= max_mag_nxt;
                    len_err   <= frame_bad;
                    frame_cnt <= frame_cnt + 16'd1;
                    first_p0  <= 1'b1;
                    cnt_p0    <= '0;
                    err_p0    <= 1'b0;
                end else begin
                    first_p0   <= 1'b0;
                    max_mag_p0 <= max_mag_nxt;
                    max_bin_p0 <= max_bin_nxt;
                    cnt_p0     <= cnt_p0 + 14'd1;
                    err_p0     <= err_p0 || bin_bad;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            // Outside a frame, re-arm so that the first word popped after SYNC starts a fresh frame.
            if (!in_frame) begin
                first_p0 <= 1'b1;
                cnt_p0   <= '0;
                err_p0   <= 1'b0;
            end
        end
    end

endmodule
